// File: rtl/blob_pkg.sv
// Shared widths, table entry layout and FSM encoding for the blob feature accumulator.
// Widths are sized for the largest supported frame; smaller frames only use the low bits.
package blob_pkg;

    localparam int unsigned HDISP_MAX = 1280;
    localparam int unsigned VDISP_MAX = 720;
    localparam int unsigned AREA_W    = $clog2(HDISP_MAX * VDISP_MAX + 1);
    localparam int unsigned X_W       = $clog2(HDISP_MAX);
    localparam int unsigned Y_W       = $clog2(VDISP_MAX);

    typedef struct packed {
        logic [AREA_W-1:0] area;
        logic [X_W-1:0]    xmin;
        logic [X_W-1:0]    xmax;
        logic [Y_W-1:0]    ymin;
        logic [Y_W-1:0]    ymax;
    } blob_entry_t;

    // Min fields start at all-ones so the first pixel always wins the compare.
    localparam blob_entry_t BLOB_EMPTY = '{area: '0, xmin: '1, xmax: '0, ymin: '1, ymax: '0};

    typedef enum logic [1:0] {StClear, StIdle, StAccum, StScan} blob_state_e;

endpackage

// File: rtl/blob_feature_accum_if.sv
// Pixel label stream in, blob records out. master = accumulator side, slave = pixel source and
// record consumer.
interface blob_feature_accum_if #(
    parameter int unsigned LABEL_W = 8
);
    import blob_pkg::*;

    logic                per_frame_vsync;
    logic                per_frame_href;
    logic [LABEL_W-1:0]  per_label;
    logic                blob_valid;
    logic                blob_ready;
    logic [LABEL_W-1:0]  blob_label;
    logic [AREA_W-1:0]   blob_area;
    logic [X_W-1:0]      blob_xmin;
    logic [X_W-1:0]      blob_xmax;
    logic [Y_W-1:0]      blob_ymin;
    logic [Y_W-1:0]      blob_ymax;
    logic                blob_last;
    logic                frame_done;
    logic [LABEL_W-1:0]  blob_count;
    logic                overrun;

    modport master (
        input  per_frame_vsync, per_frame_href, per_label, blob_ready,
        output blob_valid, blob_label, blob_area, blob_xmin, blob_xmax, blob_ymin, blob_ymax,
        output blob_last, frame_done, blob_count, overrun
    );

    modport slave (
        output per_frame_vsync, per_frame_href, per_label, blob_ready,
        input  blob_valid, blob_label, blob_area, blob_xmin, blob_xmax, blob_ymin, blob_ymax,
        input  blob_last, frame_done, blob_count, overrun
    );

endinterface

// File: rtl/blob_feature_ram.sv
// Simple dual-port label table: one synchronous read, one write, no storage reset.
// Read data holds its value while no read is issued.
module blob_feature_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WIDTH  = 32
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/blob_feature_accum.sv
// Accumulates per-label area and bounding box over a frame, then scans the table and emits
// one record per blob whose area is in range. Records lag by one qualifying entry for blob_last.
module blob_feature_accum
    import blob_pkg::*;
#(
    parameter int unsigned IMG_HDISP  = 1280,
    parameter int unsigned IMG_VDISP  = 720,
    parameter int unsigned MAX_LABELS = 256,
    parameter int unsigned LABEL_W    = 8,
    parameter int unsigned MIN_AREA   = 16,
    parameter int unsigned MAX_AREA   = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    blob_feature_accum_if.master  bus
);

    localparam logic [LABEL_W-1:0] LAST_ADDR = LABEL_W'(MAX_LABELS - 1);
    localparam logic [X_W-1:0]     X_LAST    = X_W'(IMG_HDISP - 1);
    localparam logic [Y_W-1:0]     Y_LAST    = Y_W'(IMG_VDISP - 1);

    blob_state_e state_q, state_d;

    logic               vsync_q, href_q;
    logic               vs_rise, vs_fall, href_fall;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [LABEL_W-1:0] clr_addr_q;

    // Accumulate pipeline
    logic               s0_valid;
    logic               s1_valid_q;
    logic [LABEL_W-1:0] s1_label_q;
    logic [X_W-1:0]     s1_x_q;
    logic [Y_W-1:0]     s1_y_q;
    logic               fwd_hit_q;
    blob_entry_t        fwd_entry_q;
    blob_entry_t        base, upd;

    // Scan and output
    logic [LABEL_W-1:0] scan_addr_q, rd_addr_q, cand_label_q, count_q;
    logic               scan_end_q, rd_pend_q, cand_valid_q;
    blob_entry_t        cand_entry_q, out_entry_q;
    logic               stall, consume, scan_issue, qualify, flush, scan_done;
    logic               bv_q, last_q, frame_done_q, overrun_q;
    logic [LABEL_W-1:0] out_label_q, blob_count_q;

    // RAM ports
    logic               ram_re, ram_we;
    logic [LABEL_W-1:0] ram_raddr, ram_waddr;
    blob_entry_t        ram_wdata, rd_entry;

    assign vs_rise   = bus.per_frame_vsync & ~vsync_q;
    assign vs_fall   = ~bus.per_frame_vsync & vsync_q;
    assign href_fall = href_q & ~bus.per_frame_href;
    assign s0_valid  = (state_q == StAccum) && bus.per_frame_vsync && bus.per_frame_href &&
                       (bus.per_label != '0);

    assign stall      = bv_q && !bus.blob_ready;
    assign consume    = (state_q == StScan) && rd_pend_q && !stall;
    assign scan_issue = (state_q == StScan) && !scan_end_q && (!rd_pend_q || consume);
    assign qualify    = (32'(rd_entry.area) >= MIN_AREA) && (32'(rd_entry.area) <= MAX_AREA);
    assign flush      = (state_q == StScan) && scan_end_q && !rd_pend_q && cand_valid_q && !stall;
    assign scan_done  = (state_q == StScan) && scan_end_q && !rd_pend_q && !cand_valid_q && !stall;

    // The read launched alongside the previous S1 write returns stale data; forward instead.
    always_comb begin
        base = fwd_hit_q ? fwd_entry_q : rd_entry;
        upd  = base;
        if (base.area != '1) upd.area = base.area + AREA_W'(1);
        if (s1_x_q < base.xmin) upd.xmin = s1_x_q;
        if (s1_x_q > base.xmax) upd.xmax = s1_x_q;
        if (s1_y_q < base.ymin) upd.ymin = s1_y_q;
        if (s1_y_q > base.ymax) upd.ymax = s1_y_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (clr_addr_q == LAST_ADDR) state_d = StIdle;
            StIdle:  if (vs_rise) state_d = StAccum;
            StAccum: if (vs_fall) state_d = StScan;
            StScan:  if (scan_done) state_d = StIdle;
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = scan_addr_q;
        ram_we    = 1'b0;
        ram_waddr = clr_addr_q;
        ram_wdata = BLOB_EMPTY;
        if (s0_valid) begin
            ram_re    = 1'b1;
            ram_raddr = bus.per_label;
        end else if (scan_issue) begin
            ram_re = 1'b1;
        end
        if (state_q == StClear) begin
            ram_we = 1'b1;
        end else if (s1_valid_q) begin
            ram_we    = 1'b1;
            ram_waddr = s1_label_q;
            ram_wdata = upd;
        end else if (consume) begin
            ram_we    = 1'b1;
            ram_waddr = rd_addr_q;
        end
    end

    blob_feature_ram #(
        .DEPTH  (MAX_LABELS),
        .ADDR_W (LABEL_W),
        .WIDTH  ($bits(blob_entry_t))
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rd_entry),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            clr_addr_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_label_q   <= '0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            fwd_hit_q    <= 1'b0;
            fwd_entry_q  <= BLOB_EMPTY;
            scan_addr_q  <= '0;
            rd_addr_q    <= '0;
            scan_end_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            cand_valid_q <= 1'b0;
            cand_label_q <= '0;
            cand_entry_q <= '0;
            count_q      <= '0;
            bv_q         <= 1'b0;
            last_q       <= 1'b0;
            out_label_q  <= '0;
            out_entry_q  <= '0;
            frame_done_q <= 1'b0;
            blob_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            vsync_q      <= bus.per_frame_vsync;
            href_q       <= bus.per_frame_href;
            frame_done_q <= scan_done;
            if (scan_done) blob_count_q <= count_q;
            if ((state_q == StScan || state_q == StClear) && vs_rise) overrun_q <= 1'b1;
            if (state_q == StClear) clr_addr_q <= clr_addr_q + LABEL_W'(1);

            if (state_q == StIdle && vs_rise) begin
                x_q <= '0;
                y_q <= '0;
            end else if (state_q == StAccum) begin
                if (bus.per_frame_href) begin
                    if (x_q != X_LAST) x_q <= x_q + X_W'(1);
                end else if (href_fall) begin
                    x_q <= '0;
                    if (y_q != Y_LAST) y_q <= y_q + Y_W'(1);
                end
            end

            s1_valid_q  <= s0_valid;
            fwd_hit_q   <= s0_valid && s1_valid_q && (bus.per_label == s1_label_q);
            fwd_entry_q <= upd;
            if (s0_valid) begin
                s1_label_q <= bus.per_label;
                s1_x_q     <= x_q;
                s1_y_q     <= y_q;
            end

            if (state_q == StAccum && vs_fall) begin
                scan_addr_q  <= LABEL_W'(1);
                scan_end_q   <= 1'b0;
                rd_pend_q    <= 1'b0;
                cand_valid_q <= 1'b0;
                count_q      <= '0;
            end else if (state_q == StScan) begin
                if (scan_issue) begin
                    scan_addr_q <= scan_addr_q + LABEL_W'(1);
                    rd_addr_q   <= scan_addr_q;
                    rd_pend_q   <= 1'b1;
                    if (scan_addr_q == LAST_ADDR) scan_end_q <= 1'b1;
                end else if (consume) begin
                    rd_pend_q <= 1'b0;
                end
                if (consume && qualify) begin
                    cand_valid_q <= 1'b1;
                    cand_label_q <= rd_addr_q;
                    cand_entry_q <= rd_entry;
                    count_q      <= count_q + LABEL_W'(1);
                end else if (flush) begin
                    cand_valid_q <= 1'b0;
                end
            end

            if (bv_q && bus.blob_ready) bv_q <= 1'b0;
            if ((consume && qualify && cand_valid_q) || flush) begin
                bv_q        <= 1'b1;
                last_q      <= flush;
                out_label_q <= cand_label_q;
                out_entry_q <= cand_entry_q;
            end
        end
    end

    assign bus.blob_valid = bv_q;
    assign bus.blob_label = out_label_q;
    assign bus.blob_area  = out_entry_q.area;
    assign bus.blob_xmin  = out_entry_q.xmin;
    assign bus.blob_xmax  = out_entry_q.xmax;
    assign bus.blob_ymin  = out_entry_q.ymin;
    assign bus.blob_ymax  = out_entry_q.ymax;
    assign bus.blob_last  = last_q;
    assign bus.frame_done = frame_done_q;
    assign bus.blob_count = blob_count_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_blob_feature_accum.sv
// Directed frames on an 8x8 image; expected records go into a scoreboard queue that a
// negedge monitor checks against every presented record and frame_done pulse.
module tb_blob_feature_accum;
    import blob_pkg::*;

    localparam int unsigned LW = 4;

    typedef struct packed {
        logic [LW-1:0]     label;
        logic [AREA_W-1:0] area;
        logic [X_W-1:0]    xmin;
        logic [X_W-1:0]    xmax;
        logic [Y_W-1:0]    ymin;
        logic [Y_W-1:0]    ymax;
        logic              last;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    blob_feature_accum_if #(.LABEL_W(LW)) bus ();

    blob_feature_accum #(
        .IMG_HDISP  (8),
        .IMG_VDISP  (8),
        .MAX_LABELS (16),
        .LABEL_W    (LW),
        .MIN_AREA   (4),
        .MAX_AREA   (65536)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    rec_t        sb[$];
    int          exp_cnt[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    logic [LW-1:0] img [8][8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input int l, input int a, input int x0, input int x1,
                                input int y0, input int y1, input bit last);
        rec_t r;
        r.label = LW'(l);
        r.area  = AREA_W'(a);
        r.xmin  = X_W'(x0);
        r.xmax  = X_W'(x1);
        r.ymin  = Y_W'(y0);
        r.ymax  = Y_W'(y1);
        r.last  = last;
        return r;
    endfunction

    // Monitor: every presented record is checked against the queue head; popped on handshake.
    initial begin
        rec_t act;
        forever begin
            @(negedge clk);
            if (bus.blob_valid) begin
                act = '{label: bus.blob_label, area: bus.blob_area, xmin: bus.blob_xmin,
                        xmax: bus.blob_xmax, ymin: bus.blob_ymin, ymax: bus.blob_ymax,
                        last: bus.blob_last};
                if (sb.size() == 0) begin
                    check("unexpected_record", 128'(act), 128'(0));
                end else begin
                    check(bus.blob_ready ? "record" : "record_held", 128'(act), 128'(sb[0]));
                    if (bus.blob_ready) void'(sb.pop_front());
                end
            end
            if (bus.frame_done) begin
                done_cnt++;
                if (exp_cnt.size() == 0) begin
                    check("unexpected_done", 128'(1), 128'(0));
                end else begin
                    check("blob_count", 128'(bus.blob_count), 128'(exp_cnt.pop_front()));
                    check("records_left_at_done", 128'(sb.size()), 128'(0));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) img[y][x] = '0;
    endtask

    task automatic rect(input int l, input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) img[y][x] = LW'(l);
    endtask

    task automatic drive_frame(input int nlines, input bit close);
        bus.per_frame_vsync = 1'b1;
        tick;
        tick;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < 8; x++) begin
                bus.per_frame_href = 1'b1;
                bus.per_label      = img[y][x];
                tick;
            end
            bus.per_frame_href = 1'b0;
            bus.per_label      = '0;
            repeat (3) tick;
        end
        if (close) begin
            bus.per_frame_vsync = 1'b0;
            repeat (2) tick;
        end
    endtask

    task automatic wait_done;
        for (int i = 0; i < 400 && done_cnt < done_exp; i++) tick;
        check("frame_done_count", 128'(done_cnt), 128'(done_exp));
    endtask

    task automatic run_frame;
        drive_frame(8, 1'b1);
        done_exp++;
        wait_done;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 128'(bus.blob_valid), 128'(0));
        check({tag, "_done"}, 128'(bus.frame_done), 128'(0));
        check({tag, "_count"}, 128'(bus.blob_count), 128'(0));
        check({tag, "_overrun"}, 128'(bus.overrun), 128'(0));
    endtask

    initial begin
        reset               = 1'b1;
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_label       = '0;
        bus.blob_ready      = 1'b1;
        repeat (3) tick;
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (20) tick;

        // 4x4 square of label 3
        clear_img;
        rect(3, 2, 5, 1, 4);
        sb.push_back(mk(3, 16, 2, 5, 1, 4, 1'b1));
        exp_cnt.push_back(1);
        run_frame;

        // Back-to-back same label along one line
        clear_img;
        rect(5, 0, 7, 0, 0);
        sb.push_back(mk(5, 8, 0, 7, 0, 0, 1'b1));
        exp_cnt.push_back(1);
        run_frame;

        // Small blob filtered out, twice to confirm its entry was emptied
        for (int rep = 0; rep < 2; rep++) begin
            clear_img;
            rect(2, 0, 2, 0, 0);
            rect(7, 0, 4, 2, 5);
            sb.push_back(mk(7, 20, 0, 4, 2, 5, 1'b1));
            exp_cnt.push_back(1);
            run_frame;
        end

        // Backpressure: ready low with records pending
        bus.blob_ready = 1'b0;
        clear_img;
        rect(1, 0, 1, 0, 1);
        rect(4, 4, 7, 0, 0);
        rect(12, 3, 5, 3, 5);
        rect(9, 0, 7, 7, 7);
        sb.push_back(mk(1, 4, 0, 1, 0, 1, 1'b0));
        sb.push_back(mk(4, 4, 4, 7, 0, 0, 1'b0));
        sb.push_back(mk(9, 8, 0, 7, 7, 7, 1'b0));
        sb.push_back(mk(12, 9, 3, 5, 3, 5, 1'b1));
        exp_cnt.push_back(4);
        drive_frame(8, 1'b1);
        done_exp++;
        repeat (14) tick;
        check("stalled_no_done", 128'(done_cnt), 128'(done_exp - 1));
        check("stalled_pending", 128'(sb.size()), 128'(4));
        bus.blob_ready = 1'b1;
        wait_done;

        // Vsync rise during scan drops the second frame
        check("overrun_before", 128'(bus.overrun), 128'(0));
        clear_img;
        rect(3, 2, 5, 1, 4);
        sb.push_back(mk(3, 16, 2, 5, 1, 4, 1'b1));
        exp_cnt.push_back(1);
        drive_frame(8, 1'b1);
        done_exp++;
        repeat (2) tick;
        clear_img;
        rect(6, 0, 7, 0, 7);
        drive_frame(8, 1'b1);
        wait_done;
        check("overrun_after", 128'(bus.overrun), 128'(1));
        clear_img;
        rect(8, 1, 3, 2, 6);
        sb.push_back(mk(8, 15, 1, 3, 2, 6, 1'b1));
        exp_cnt.push_back(1);
        run_frame;

        // Reset in the middle of accumulation
        clear_img;
        rect(10, 0, 7, 0, 0);
        drive_frame(3, 1'b0);
        reset               = 1'b1;
        bus.per_frame_vsync = 1'b0;
        #1;
        check_idle_outputs("midframe_reset");
        tick;
        tick;
        reset = 1'b0;
        repeat (20) tick;
        clear_img;
        rect(10, 0, 1, 6, 7);
        sb.push_back(mk(10, 4, 0, 1, 6, 7, 1'b1));
        exp_cnt.push_back(1);
        run_frame;

        repeat (5) tick;
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
